// File: rtl/mant_seq_mult_pkg.sv
// Shared definitions for the sequential mantissa multiplier: FSM encoding
// and the default mantissa width (hidden bit included).
package mant_seq_mult_pkg;

  localparam int SIZE_DEFAULT = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mant_seq_mult_adder.sv
// SIZE-bit ripple-carry adder; the carry-out becomes bit SIZE of the
// partial-product sum in the multiplier.
module mant_seq_mult_adder
  import mant_seq_mult_pkg::*;
#(
  parameter int SIZE = SIZE_DEFAULT
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE-1:0] sum,
  output logic            cout
);

  logic [SIZE:0] carry;

  always_comb begin
    carry = '0;
    sum   = '0;
    for (int i = 0; i < SIZE; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[SIZE];
  end

endmodule

// File: rtl/mant_seq_mult.sv
// Shift-and-add unsigned mantissa multiplier, one multiplier bit per cycle.
// Optional normalisation outputs are enabled with macro MANT_NORM_EN.
module mant_seq_mult
  import mant_seq_mult_pkg::*;
#(
  parameter int SIZE = SIZE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*SIZE-1:0] prod
`ifdef MANT_NORM_EN
  ,
  output logic [SIZE-2:0]   norm_mant,
  output logic              exp_inc
`endif
);

  localparam int CNT_W = $clog2(SIZE + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SIZE - 1);

  state_e              state_q, state_d;
  logic [SIZE-1:0]     mcand_q, mcand_d;
  logic [SIZE-1:0]     acc_q, acc_d;
  logic [SIZE-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*SIZE-1:0]   prod_q, prod_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [SIZE-1:0]     addend;
  logic [SIZE-1:0]     sum;
  logic                cout;
`ifdef MANT_NORM_EN
  logic [SIZE-2:0]     norm_mant_q, norm_mant_d;
  logic                exp_inc_q, exp_inc_d;
`endif

  assign addend = mplier_q[0] ? mcand_q : '0;

  mant_seq_mult_adder #(.SIZE(SIZE)) u_adder (
    .a    (acc_q),
    .b    (addend),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = CALC;
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        // {carry, sum, multiplier} shifted right one place
        acc_d    = {cout, sum[SIZE-1:1]};
        mplier_d = {sum[0], mplier_q[SIZE-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          prod_d  = {cout, sum, mplier_q[SIZE-1:1]};
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CALC);
  end

`ifdef MANT_NORM_EN
  always_comb begin
    exp_inc_d   = prod_d[2*SIZE-1];
    norm_mant_d = prod_d[2*SIZE-1] ? prod_d[2*SIZE-2:SIZE] : prod_d[2*SIZE-3:SIZE-1];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      acc_q       <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      prod_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MANT_NORM_EN
      norm_mant_q <= '0;
      exp_inc_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef MANT_NORM_EN
      norm_mant_q <= norm_mant_d;
      exp_inc_q   <= exp_inc_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign prod = prod_q;
`ifdef MANT_NORM_EN
  assign norm_mant = norm_mant_q;
  assign exp_inc   = exp_inc_q;
`endif

endmodule

// File: tb/tb_mant_seq_mult.sv
// Directed bench for mant_seq_mult (SIZE=24); norm outputs checked when
// MANT_NORM_EN is defined.
module tb_mant_seq_mult;

  logic        clk;
  logic        rst;
  logic        start;
  logic [23:0] a;
  logic [23:0] b;
  logic        busy;
  logic        done;
  logic [47:0] prod;
`ifdef MANT_NORM_EN
  logic [22:0] norm_mant;
  logic        exp_inc;
`endif

  int n_checks = 0;
  int n_errors = 0;

  mant_seq_mult #(.SIZE(24)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .prod  (prod)
`ifdef MANT_NORM_EN
    ,
    .norm_mant (norm_mant),
    .exp_inc   (exp_inc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge at a time until done is seen or the budget runs out.
  task automatic wait_done(input int c0, input int b0, output int c, output int bc);
    c  = c0;
    bc = b0;
    while (done !== 1'b1 && c < 40) begin
      @(posedge clk);
      #1;
      c++;
      if (busy === 1'b1) bc++;
    end
  endtask

  // Drive start now; sample after the edge that takes it, then drop start.
  task automatic issue(input logic [23:0] av, input logic [23:0] bv, output int c, output int bc);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    c     = 1;
    bc    = (busy === 1'b1) ? 1 : 0;
  endtask

  initial begin
    int c;
    int bc;
    int dcount;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_prod", 64'(prod), 64'd0);
`ifdef MANT_NORM_EN
    chk("reset_norm", 64'(norm_mant), 64'd0);
    chk("reset_expinc", 64'(exp_inc), 64'd0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 0x800000 squared
    issue(24'h800000, 24'h800000, c, bc);
    wait_done(c, bc, c, bc);
    chk("half_sq_latency", 64'(c), 64'd25);
    chk("half_sq_busy_cycles", 64'(bc), 64'd24);
    chk("half_sq_prod", 64'(prod), 64'h4000_0000_0000);
    @(posedge clk);
    #1;
    chk("half_sq_done_pulse", 64'(done), 64'd0);
    chk("half_sq_idle_busy", 64'(busy), 64'd0);
    chk("half_sq_prod_hold", 64'(prod), 64'h4000_0000_0000);

    // all-ones squared
    issue(24'hFFFFFF, 24'hFFFFFF, c, bc);
    wait_done(c, bc, c, bc);
    chk("ones_latency", 64'(c), 64'd25);
    chk("ones_busy_cycles", 64'(bc), 64'd24);
    chk("ones_prod", 64'(prod), 64'hFFFF_FE00_0001);
    @(posedge clk);
    #1;

    // zero times 0xABCDEF, with an ignored start at CALC cycle 5
    issue(24'h000000, 24'hABCDEF, c, bc);
    repeat (4) begin
      @(posedge clk);
      #1;
      c++;
    end
    start = 1'b1;
    a     = 24'hFFFFFF;
    b     = 24'hFFFFFF;
    @(posedge clk);
    #1;
    c++;
    start = 1'b0;
    chk("ignore_start_busy", 64'(busy), 64'd1);
    wait_done(c, 0, c, bc);
    chk("ignore_start_latency", 64'(c), 64'd25);
    chk("ignore_start_prod", 64'(prod), 64'd0);
    @(posedge clk);
    #1;

    // reset at CALC cycle 10 abandons the multiply
    issue(24'hFFFFFF, 24'hFFFFFF, c, bc);
    repeat (9) @(posedge clk);
    #1;
    chk("pre_abort_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_prod", 64'(prod), 64'd0);
    dcount = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dcount++;
    end
    chk("abort_no_done", 64'(dcount), 64'd0);
    chk("abort_stays_idle", 64'(busy), 64'd0);

    // back-to-back: start held in DONE
    issue(24'h800000, 24'h800000, c, bc);
    wait_done(c, bc, c, bc);
    chk("b2b_first_latency", 64'(c), 64'd25);
    chk("b2b_first_prod", 64'(prod), 64'h4000_0000_0000);
    issue(24'hC00000, 24'hC00000, c, bc);
    chk("b2b_calc_next", 64'(busy), 64'd1);
    chk("b2b_done_low", 64'(done), 64'd0);
    wait_done(c, bc, c, bc);
    chk("b2b_second_latency", 64'(c), 64'd25);
    chk("b2b_second_prod", 64'(prod), 64'h9000_0000_0000);
`ifdef MANT_NORM_EN
    chk("b2b_expinc", 64'(exp_inc), 64'd1);
    chk("b2b_norm", 64'(norm_mant), 64'h100000);
`endif
    @(posedge clk);
    #1;

    // 0x800000 * 0xC00000: no exponent increment
    issue(24'h800000, 24'hC00000, c, bc);
    wait_done(c, bc, c, bc);
    chk("mixed_latency", 64'(c), 64'd25);
    chk("mixed_prod", 64'(prod), 64'h6000_0000_0000);
`ifdef MANT_NORM_EN
    chk("mixed_expinc", 64'(exp_inc), 64'd0);
    chk("mixed_norm", 64'(norm_mant), 64'h400000);
`endif
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
